// File: rtl/mod_cfg_sequencer_if.sv
// mod_cfg_if: configuration request bus (valid/ready plus requested settings)
interface mod_cfg_if;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_mod_type;
  logic [1:0] cfg_baud_rate;
  logic cfg_filter_enable;
  logic cfg_use_sqrt_rcos;
  logic [15:0] cfg_carrier_freq;
  modport master (
    output cfg_valid, cfg_mod_type, cfg_baud_rate, cfg_filter_enable, cfg_use_sqrt_rcos, cfg_carrier_freq,
    input cfg_ready
  );
  modport slave (
    input cfg_valid, cfg_mod_type, cfg_baud_rate, cfg_filter_enable, cfg_use_sqrt_rcos, cfg_carrier_freq,
    output cfg_ready
  );
endinterface

// File: rtl/mod_cfg_sequencer.sv
// mod_cfg_sequencer: symbol-aligned run-time configuration controller for the QAM modulator chain
module mod_cfg_sequencer #(
  parameter int FLUSH_CYCLES = 16,
  parameter int SETTLE_SYMS = 8,
  parameter int ALIGN_TIMEOUT = 65535,
  parameter logic [1:0] DEFAULT_BAUD = 2'b00,
  parameter logic [15:0] DEFAULT_CARRIER = 16'd10000
) (
  input logic clk,
  input logic rst,
  input logic sym_tick,
  mod_cfg_if.slave cfg,
  output logic mod_type,
  output logic [1:0] baud_rate,
  output logic filter_enable,
  output logic use_sqrt_rcos,
  output logic [15:0] carrier_freq_set,
  output logic dp_rst_n,
  output logic tx_mute,
  output logic cfg_done,
  output logic align_timeout_err
);
  typedef enum logic [1:0] {FLUSH, SETTLE, RUN, ALIGN} state_t;
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_SYMS - 1);
  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_TIMEOUT);
  state_t state, state_nx;
  logic [15:0] cnt, cnt_nx, cnt_inc;
  logic sh_mod, sh_filt, sh_sqrt;
  logic [1:0] sh_baud;
  logic [15:0] sh_car;
  logic pending, hs, leave, structural, settled, done_nx;
  assign cnt_inc = &cnt ? cnt : cnt + 16'd1;
  assign hs = state == RUN && cfg.cfg_valid;
  assign leave = state == ALIGN && (sym_tick || cnt >= ALIGN_LAST);
  assign structural = {sh_mod, sh_baud, sh_filt, sh_sqrt} != {mod_type, baud_rate, filter_enable, use_sqrt_rcos};
  assign settled = state == SETTLE && sym_tick && cnt == SETTLE_LAST;
  assign done_nx = (settled && pending) || (leave && !structural);
  assign cfg.cfg_ready = state == RUN;
  assign dp_rst_n = state != FLUSH;
  assign tx_mute = state == FLUSH || state == SETTLE;
  // next state and shared cycle/tick/timeout counter
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      FLUSH: begin
        state_nx = cnt == FLUSH_LAST ? SETTLE : FLUSH;
        cnt_nx = cnt == FLUSH_LAST ? '0 : cnt_inc;
      end
      SETTLE: begin
        state_nx = settled ? RUN : SETTLE;
        cnt_nx = settled ? '0 : sym_tick ? cnt_inc : cnt;
      end
      RUN: begin
        state_nx = hs ? ALIGN : RUN;
        cnt_nx = '0;
      end
      ALIGN: begin
        state_nx = leave ? (structural ? FLUSH : RUN) : ALIGN;
        cnt_nx = leave ? '0 : cnt_inc;
      end
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FLUSH;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // shadow capture on handshake, active settings on align exit, done/error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mod_type <= 1'b0;
      baud_rate <= DEFAULT_BAUD;
      filter_enable <= 1'b0;
      use_sqrt_rcos <= 1'b0;
      carrier_freq_set <= DEFAULT_CARRIER;
      sh_mod <= 1'b0;
      sh_baud <= DEFAULT_BAUD;
      sh_filt <= 1'b0;
      sh_sqrt <= 1'b0;
      sh_car <= DEFAULT_CARRIER;
      pending <= 1'b0;
      cfg_done <= 1'b0;
      align_timeout_err <= 1'b0;
    end else begin
      cfg_done <= done_nx;
      if (hs) begin
        sh_mod <= cfg.cfg_mod_type;
        sh_baud <= cfg.cfg_baud_rate;
        sh_filt <= cfg.cfg_filter_enable;
        sh_sqrt <= cfg.cfg_use_sqrt_rcos;
        sh_car <= cfg.cfg_carrier_freq;
      end
      pending <= hs ? 1'b1 : done_nx ? 1'b0 : pending;
      if (leave) begin
        mod_type <= sh_mod;
        baud_rate <= sh_baud;
        filter_enable <= sh_filt;
        use_sqrt_rcos <= sh_sqrt;
        carrier_freq_set <= sh_car;
      end
      if (leave && !sym_tick) align_timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mod_cfg_sequencer.sv
// tb_mod_cfg_sequencer: directed stimulus with a per-cycle behavioural reference model
module tb_mod_cfg_sequencer;
  localparam int FC = 16;
  localparam int SS = 8;
  localparam int AT = 100;
  localparam int TP = 50;
  logic clk = 0, rst = 1, sym_tick = 0, tick_en = 1;
  logic mod_type, filter_enable, use_sqrt_rcos, dp_rst_n, tx_mute, cfg_done, align_timeout_err;
  logic [1:0] baud_rate;
  logic [15:0] carrier_freq_set;
  int checks = 0, passes = 0;
  int n_low = 0, n_mute = 0, n_done = 0;
  mod_cfg_if bus ();
  mod_cfg_sequencer #(.FLUSH_CYCLES(FC), .SETTLE_SYMS(SS), .ALIGN_TIMEOUT(AT),
                      .DEFAULT_BAUD(2'b00), .DEFAULT_CARRIER(16'd10000)) dut (
    .clk(clk), .rst(rst), .sym_tick(sym_tick), .cfg(bus),
    .mod_type(mod_type), .baud_rate(baud_rate), .filter_enable(filter_enable),
    .use_sqrt_rcos(use_sqrt_rcos), .carrier_freq_set(carrier_freq_set),
    .dp_rst_n(dp_rst_n), .tx_mute(tx_mute), .cfg_done(cfg_done),
    .align_timeout_err(align_timeout_err)
  );
  always #5 clk = ~clk;

  initial forever begin
    repeat (TP - 1) @(posedge clk);
    #1 sym_tick = tick_en;
    @(posedge clk);
    #1 sym_tick = 0;
  end

  // reference model: remaining flush cycles, remaining settle ticks, align age, pending request
  int flush_left = 0, settle_left = 0, age = 0;
  bit in_align = 0, pending = 0, m_err = 0, m_done = 0, mv = 0, strct;
  logic m_mod = 0, m_filt = 0, m_sqrt = 0, s_mod = 0, s_filt = 0, s_sqrt = 0;
  logic [1:0] m_baud = 0, s_baud = 0;
  logic [15:0] m_car = 0, s_car = 0;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      {m_mod, m_baud, m_filt, m_sqrt, m_car} = {1'b0, 2'b00, 1'b0, 1'b0, 16'd10000};
      flush_left = FC; settle_left = SS; in_align = 0; pending = 0; m_err = 0; m_done = 0; mv = 1;
    end else if (mv) begin
      m_done = 0;
      if (flush_left > 0) flush_left--;
      else if (settle_left > 0) begin
        if (sym_tick) begin
          settle_left--;
          if (settle_left == 0 && pending) begin m_done = 1; pending = 0; end
        end
      end else if (in_align) begin
        if (sym_tick || age >= AT) begin
          if (!sym_tick) m_err = 1;
          strct = {s_mod, s_baud, s_filt, s_sqrt} != {m_mod, m_baud, m_filt, m_sqrt};
          {m_mod, m_baud, m_filt, m_sqrt, m_car} = {s_mod, s_baud, s_filt, s_sqrt, s_car};
          in_align = 0;
          if (strct) begin flush_left = FC; settle_left = SS; end
          else begin m_done = 1; pending = 0; end
        end else age++;
      end else if (bus.cfg_valid) begin
        {s_mod, s_baud, s_filt, s_sqrt, s_car} = {bus.cfg_mod_type, bus.cfg_baud_rate,
          bus.cfg_filter_enable, bus.cfg_use_sqrt_rcos, bus.cfg_carrier_freq};
        pending = 1; in_align = 1; age = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // compare every cycle against the model; tally activity for the directed checks
  initial forever begin
    @(negedge clk);
    if (mv) begin
      chk("mod_type", 16'(mod_type), 16'(m_mod));
      chk("baud_rate", 16'(baud_rate), 16'(m_baud));
      chk("filter_enable", 16'(filter_enable), 16'(m_filt));
      chk("use_sqrt_rcos", 16'(use_sqrt_rcos), 16'(m_sqrt));
      chk("carrier_freq_set", carrier_freq_set, m_car);
      chk("dp_rst_n", 16'(dp_rst_n), 16'(flush_left == 0));
      chk("tx_mute", 16'(tx_mute), 16'(flush_left > 0 || settle_left > 0));
      chk("cfg_ready", 16'(bus.cfg_ready), 16'(flush_left == 0 && settle_left == 0 && !in_align));
      chk("cfg_done", 16'(cfg_done), 16'(m_done));
      chk("align_timeout_err", 16'(align_timeout_err), 16'(m_err));
      n_low += int'(!dp_rst_n);
      n_mute += int'(tx_mute);
      n_done += int'(cfg_done);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.cfg_ready && n < 5000) begin @(negedge clk); n++; end
    chk({"wait_", name}, 16'(n < 5000), 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic m, input logic [1:0] b, input logic f, input logic s, input logic [15:0] c);
    {bus.cfg_mod_type, bus.cfg_baud_rate, bus.cfg_filter_enable, bus.cfg_use_sqrt_rcos, bus.cfg_carrier_freq} = {m, b, f, s, c};
  endtask

  task automatic handshake(input string name);
    int n = 0;
    bus.cfg_valid = 1;
    while (!bus.cfg_ready && n < 5000) begin @(negedge clk); n++; end
    chk({"hs_", name}, 16'(n < 5000), 16'd1);
    @(posedge clk);
    #1;
  endtask

  int l0, m0, d0, n;
  initial begin
    bus.cfg_valid = 0;
    set_data(0, 2'b00, 0, 0, 16'd0);
    cyc(3);
    rst = 0;
    l0 = n_low; d0 = n_done;
    wait_ready("reset");
    chk("t1_low_cycles", 16'(n_low - l0), 16'd16);
    chk("t1_no_done", 16'(n_done - d0), 16'd0);
    chk("t1_carrier", carrier_freq_set, 16'd10000);

    l0 = n_low; d0 = n_done;
    set_data(1, 2'b10, 0, 0, 16'd10000);
    handshake("t2"); bus.cfg_valid = 0;
    wait_ready("t2");
    chk("t2_mod", 16'(mod_type), 16'd1);
    chk("t2_baud", 16'(baud_rate), 16'd2);
    chk("t2_low_cycles", 16'(n_low - l0), 16'd16);
    chk("t2_done", 16'(n_done - d0), 16'd1);

    l0 = n_low; m0 = n_mute; d0 = n_done;
    set_data(1, 2'b10, 0, 0, 16'd20000);
    handshake("t3"); bus.cfg_valid = 0;
    wait_ready("t3");
    chk("t3_carrier", carrier_freq_set, 16'd20000);
    chk("t3_low", 16'(n_low - l0), 16'd0);
    chk("t3_mute", 16'(n_mute - m0), 16'd0);
    chk("t3_done", 16'(n_done - d0), 16'd1);

    tick_en = 0;
    cyc(TP + 2);
    set_data(1, 2'b10, 1, 0, 16'd20000);
    handshake("t4"); bus.cfg_valid = 0;
    n = 0;
    while (dp_rst_n && n < 300) begin @(negedge clk); n++; end
    chk("t4_force_latency", 16'(n), 16'd102);
    chk("t4_err", 16'(align_timeout_err), 16'd1);
    tick_en = 1;
    wait_ready("t4");
    chk("t4_err_held", 16'(align_timeout_err), 16'd1);
    chk("t4_filter", 16'(filter_enable), 16'd1);

    set_data(1, 2'b01, 1, 1, 16'd30000);
    handshake("t5"); bus.cfg_valid = 0;
    n = 0;
    while (!(dp_rst_n && tx_mute) && n < 500) begin @(negedge clk); n++; end
    chk("t5_reach_settle", 16'(n < 500), 16'd1);
    cyc(2);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("t5_mod_default", 16'(mod_type), 16'd0);
    chk("t5_carrier_default", carrier_freq_set, 16'd10000);
    chk("t5_err_cleared", 16'(align_timeout_err), 16'd0);
    l0 = n_low; d0 = n_done;
    wait_ready("t5");
    chk("t5_low_cycles", 16'(n_low - l0), 16'd16);
    chk("t5_no_done", 16'(n_done - d0), 16'd0);

    d0 = n_done;
    set_data(1, 2'b11, 0, 1, 16'd12345);
    handshake("t6a");
    set_data(0, 2'b01, 1, 0, 16'd777);
    n = 0;
    while (!bus.cfg_ready && n < 5000) begin @(negedge clk); n++; end
    chk("t6_first_mod", 16'(mod_type), 16'd1);
    chk("t6_first_baud", 16'(baud_rate), 16'd3);
    chk("t6_first_car", carrier_freq_set, 16'd12345);
    @(posedge clk);
    #1 bus.cfg_valid = 0;
    set_data(1, 2'b11, 1, 1, 16'd4242);
    wait_ready("t6b");
    chk("t6_second_mod", 16'(mod_type), 16'd0);
    chk("t6_second_baud", 16'(baud_rate), 16'd1);
    chk("t6_second_car", carrier_freq_set, 16'd777);
    chk("t6_done", 16'(n_done - d0), 16'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
